gcd_engine: RTL
===============

GCD_ENGINE -- requirements
Module: gcd_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width in bits; legal range 2..64.
REQ-002 SHALL have parameter CNT_W, default 16: iteration counter width in bits; legal range 1..32.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port a_in  input  WIDTH  operand A; sampled with start.
REQ-007 SHALL have port b_in  input  WIDTH  operand B; sampled with start.
REQ-008 SHALL have port busy  output  1  high in LOAD/CALC/DONE.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port result  output  WIDTH  GCD of the last job; held until the next job completes.
REQ-011 SHALL have port err  output  1  last job had a_in==0 and b_in==0; held like result.

Function
REQ-012 SHALL implement states IDLE, CALC and DONE, plus the LOAD transition (taken from IDLE, not a separate state); encoding is free.
REQ-013 LOAD: in IDLE with start=1, the engine SHALL register A<=a_in and B<=b_in, clear the iteration count and enter CALC, except in the zero cases of REQ-016.
REQ-014 CALC: each cycle SHALL do exactly one of the following:
- A==B: result<=A, err<=0, go to DONE.
- A>B: A<=A-B.
- A<B: B<=B-A.
REQ-015 Subtraction SHALL be WIDTH-bit unsigned with no wrap; the smaller operand is always subtracted from the larger.
REQ-016 Zero operands: if exactly one operand is 0, result SHALL be the other operand (err=0); if both are 0, result=0 and err=1; both cases go directly from IDLE to DONE, skipping CALC.
REQ-017 Latency, sample edge to done rising: (number of subtract cycles + 2) edges for CALC jobs, 1 edge for zero-operand jobs.
REQ-018 DONE SHALL assert done for exactly one cycle, then return to IDLE; busy SHALL drop in the same cycle done drops.
REQ-019 start while busy=1 SHALL be ignored, with no queuing.
REQ-020 A start in the same cycle that done is high SHALL be ignored; a new job is accepted only from IDLE.
REQ-021 result and err SHALL change only at DONE entry.

Reset
REQ-022 rst_n=0 SHALL immediately force:
- state=IDLE
- A=0, B=0, result=0
- err=0, done=0, busy=0
- iter_cnt=0, iter_sat=0 when present.
REQ-023 Reset asserted mid-computation SHALL abort the job without a done pulse; the first start after deassertion SHALL be accepted normally.

Configuration
REQ-024 Macro GCD_ITER_CNT_EN: when defined, the module SHALL add the following outputs:
- iter_cnt (CNT_W bits): counts CALC subtract cycles of the current job, latched with result at DONE entry.
- iter_sat (1 bit): high when the count saturated at 2^CNT_W-1; the counter SHALL saturate, never wrap.
REQ-025 Without GCD_ITER_CNT_EN, these ports and counter logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-026 a_in=12, b_in=8, start pulse -> A,B sequence 12/8, 4/8, 4/4; done 4 edges after sampling; result=4, err=0, iter_cnt=2.
REQ-027 a_in=7, b_in=7 -> done 2 edges after sampling; result=7, iter_cnt=0.
REQ-028 Zero-operand cases:
- a_in=0, b_in=9 -> done 1 edge after sampling; result=9, err=0.
- a_in=0, b_in=0 -> done 1 edge after sampling; result=0, err=1.
REQ-029 a_in=65535, b_in=1 with WIDTH=16 -> 65534 subtract cycles; result=1; with CNT_W=8, iter_cnt=255 and iter_sat=1.
REQ-030 Busy-period stimulus:
- Start gcd(48,18); pulse start with 5/3 during CALC -> ignored; result=6 and only one done pulse.
- rst_n low mid-job -> outputs zero, no done; next gcd(10,4) -> result=2.

Source files
------------

// File: rtl/gcd_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gcd_engine: subtractive-Euclid GCD, one subtract per cycle.              |
// | Optional iteration counter: define GCD_ITER_CNT_EN.                      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module gcd_engine #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
`ifdef GCD_ITER_CNT_EN
  ,
  output logic [CNT_W-1:0] iter_cnt,
  output logic             iter_sat
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_err;
  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] w_b_nxt;
  logic [WIDTH-1:0] w_res_nxt;
  logic             w_err_nxt;
  logic             w_a_zero;
  logic             w_b_zero;

  assign w_a_zero = (a_in == '0);
  assign w_b_zero = (b_in == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_res_nxt   = r_result;
    w_err_nxt   = r_err;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          // A zero operand makes the answer immediate, so CALC is skipped.
          if (w_a_zero || w_b_zero) begin
            w_state_nxt = S_DONE;
            w_res_nxt   = a_in | b_in;
            w_err_nxt   = w_a_zero && w_b_zero;
          end else begin
            w_state_nxt = S_CALC;
            w_a_nxt     = a_in;
            w_b_nxt     = b_in;
          end
        end
      end
      S_CALC: begin
        if (r_a == r_b) begin
          w_state_nxt = S_DONE;
          w_res_nxt   = r_a;
          w_err_nxt   = 1'b0;
        end else if (r_a > r_b) begin
          w_a_nxt = r_a - r_b;
        end else begin
          w_b_nxt = r_b - r_a;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      r_a      <= w_a_nxt;
      r_b      <= w_b_nxt;
      r_result <= w_res_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign err    = r_err;

`ifdef GCD_ITER_CNT_EN
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  logic             w_load;
  logic             w_sub;
  logic             w_latch;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_iter_cnt;
  logic             r_iter_sat;

  assign w_load  = (r_state == S_IDLE) && start && !w_a_zero && !w_b_zero;
  assign w_sub   = (r_state == S_CALC) && (r_a != r_b);
  assign w_latch = (w_state_nxt == S_DONE) && (r_state != S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_iter_cnt <= '0;
      r_iter_sat <= 1'b0;
    end else begin
      if (w_load) begin
        r_cnt <= '0;
      end else if (w_sub && (r_cnt != C_CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      // Zero-operand jobs never pass through CALC, so they report no iterations.
      if (w_latch) begin
        r_iter_cnt <= (r_state == S_IDLE) ? '0 : r_cnt;
        r_iter_sat <= (r_state != S_IDLE) && (r_cnt == C_CNT_MAX);
      end
    end
  end

  assign iter_cnt = r_iter_cnt;
  assign iter_sat = r_iter_sat;
`endif

endmodule
`default_nettype wire
